// File: rtl/tile_vec_tx.sv
// tile_vec_tx: reads one frame of packed 64-bit words from a fixed-latency memory
// and streams them as 4-lane beats. Optional inter-beat gap: TILE_TX_GAP_EN.
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | issuing reads and transmitting beats
//   DONE  | one-cycle done pulse
`timescale 1ns/1ps
module tile_vec_tx #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int D          = 256,
    parameter int TILE_DEPTH = D / TILE_SIZE,
    parameter int ADDR_W     = $clog2(TILE_DEPTH),
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      mem_en_o,
    output logic [ADDR_W-1:0]                         mem_addr_o,
    input  logic [63:0]                               mem_rdata_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] out_vec_o,
    output logic                                      out_sof_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < MEM_LAT + 2 || GAP_CYC < 1 || TILE_SIZE * DATA_WIDTH != 64) begin : g_cfg_err
        $error("tile_vec_tx: unsupported parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0]  tx_idx_q, tx_idx_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic               mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [MEM_LAT-1:0] lat_q;

    logic [63:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fcnt_q;

    logic fifo_empty, fifo_clr, push, pop, can_issue;

    assign fifo_empty = (fcnt_q == '0);
    assign push       = lat_q[MEM_LAT-1];
    assign pop        = out_valid_o && out_ready_i;

    // A pop frees its slot in the same cycle, so a read may reuse it at once;
    // without this the pipeline bubbles once the credits run dry.
    assign can_issue = (state_q == S_RUN) && (rd_idx_q < (ADDR_W+1)'(TILE_DEPTH))
                       && ((credits_q != '0) || pop);

    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        tx_idx_d   = tx_idx_q;
        credits_d  = credits_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        fifo_clr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // Entering RUN issues the read of word 0 on the same edge.
                    state_d    = S_RUN;
                    rd_idx_d   = (ADDR_W+1)'(1);
                    tx_idx_d   = '0;
                    credits_d  = CNT_W'(FIFO_DEPTH - 1);
                    mem_en_d   = 1'b1;
                    mem_addr_d = '0;
                    fifo_clr   = 1'b1;
                end
            end
            S_RUN: begin
                if (can_issue) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = rd_idx_q[ADDR_W-1:0];
                    rd_idx_d   = rd_idx_q + 1'b1;
                end
                unique case ({can_issue, pop})
                    2'b10:   credits_d = credits_q - 1'b1;
                    2'b01:   credits_d = credits_q + 1'b1;
                    default: credits_d = credits_q;
                endcase
                if (pop) begin
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q == ADDR_W'(TILE_DEPTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            tx_idx_q   <= '0;
            credits_q  <= CNT_W'(FIFO_DEPTH);
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            tx_idx_q   <= tx_idx_d;
            credits_q  <= credits_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            lat_q[0]   <= mem_en_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                lat_q[i] <= lat_q[i-1];
            end
        end
    end

    // Skid FIFO; credits guarantee a push never lands on a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rdata_i;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

`ifdef TILE_TX_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    logic [GAP_W-1:0] gap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (fifo_clr) begin
            gap_q <= '0;
        end else if (pop) begin
            gap_q <= GAP_W'(GAP_CYC);
        end else if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
        end
    end

    assign out_valid_o = !fifo_empty && (gap_q == '0);
`else
    assign out_valid_o = !fifo_empty;
`endif

    assign out_vec_o  = fifo_q[rd_ptr_q];
    assign out_sof_o  = out_valid_o && (tx_idx_q == '0);
    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign mem_en_o   = mem_en_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_tile_vec_tx.sv
// Self-checking bench for tile_vec_tx: directed frame table, backpressure,
// random ready, mid-frame reset, and the gap mode when TILE_TX_GAP_EN is defined.
`timescale 1ns/1ps
module tb_tile_vec_tx;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start_i;
    logic                     busy_o, done_o, mem_en_o;
    logic [5:0]               mem_addr_o;
    logic [63:0]              mem_rdata_i;
    logic                     out_valid_o, out_ready_i, out_sof_o;
    logic signed [3:0][15:0]  out_vec_o;

    tile_vec_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_vec_o   (out_vec_o),
        .out_sof_o   (out_sof_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int beats   = 0;
    int sofs    = 0;
    bit mon_en  = 1'b0;

    function automatic logic [63:0] word_of(input int i);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[16*k +: 16] = 16'(i*4 + k);
        return w;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source memory with two-cycle read latency.
    logic [63:0] mem_d1;
    always @(posedge clk) begin
        mem_d1      <= mem_en_o ? word_of(int'(mem_addr_o)) : 64'hDEAD_BEEF_DEAD_BEEF;
        mem_rdata_i <= mem_d1;
    end

    // Beat scoreboard and hold-under-backpressure monitor.
    bit          prev_stall = 1'b0;
    logic [63:0] prev_vec;
    logic        prev_sof;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", longint'(out_valid_o), 1);
                chk("hold_vec", longint'(out_vec_o), longint'(prev_vec));
                chk("hold_sof", longint'(out_sof_o), longint'(prev_sof));
            end
            if (out_valid_o && out_ready_i) begin
                chk("beat_data", longint'(out_vec_o), longint'(word_of(beats)));
                chk("beat_sof", longint'(out_sof_o), (beats == 0) ? 1 : 0);
                beats++;
                if (out_sof_o) sofs++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_vec   = out_vec_o;
            prev_sof   = out_sof_o;
        end
    end

    // mode 0: ready held high, 1: random ready, 2: stall while beat 10 is at the head
    task automatic run_frame(input int mode, input int glitch_cyc, input bit start_on_done);
        bit got_done    = 1'b0;
        bit stalled     = 1'b0;
        int stall_left  = 0;
        int stall_en    = 0;
        int resume_left = 0;
        beats = 0;
        sofs  = 0;
        mon_en = 1'b1;
        start_i = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int cyc = 1; cyc < 3000 && !got_done; cyc++) begin
            if (done_o) begin
                got_done = 1'b1;
                start_i  = start_on_done;
            end else begin
                start_i = (cyc == glitch_cyc);
                case (mode)
                    1: out_ready_i = 1'($urandom_range(0, 1));
                    2: begin
                        if (!stalled && beats == 10 && out_valid_o) begin
                            stalled    = 1'b1;
                            stall_left = 10;
                        end
                        if (stall_left > 0) begin
                            out_ready_i = 1'b0;
                            if (mem_en_o) stall_en++;
                            stall_left--;
                            if (stall_left == 0) resume_left = 8;
                        end else begin
                            out_ready_i = 1'b1;
`ifndef TILE_TX_GAP_EN
                            if (resume_left > 0) begin
                                chk("resume_no_bubble", longint'(out_valid_o), 1);
                                resume_left--;
                            end
`endif
                        end
                    end
                    default: out_ready_i = 1'b1;
                endcase
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        out_ready_i = 1'b1;
        chk("frame_done_seen", got_done, 1);
        chk("done_one_cycle", longint'(done_o), 0);
        chk("idle_after_done", longint'(busy_o), 0);
        chk("frame_beats", beats, 64);
        chk("frame_sof_count", sofs, 1);
        if (mode == 2) begin
            chk("stall_seen", stalled, 1);
            chk("stall_mem_en_le_depth", (stall_en <= 4) ? 1 : 0, 1);
        end
    endtask

`ifndef TILE_TX_GAP_EN
    typedef struct {
        int cyc;
        bit busy, done, mem_en;
        int addr;
        bit valid, sof, chk_vec;
        int lane0, lane3;
    } vec_t;
    vec_t tbl [11];

    bit obs_busy [0:79], obs_done [0:79], obs_en [0:79], obs_valid [0:79], obs_sof [0:79];
    int obs_addr [0:79], obs_l0 [0:79], obs_l3 [0:79];

    task automatic rec(input int c);
        obs_busy[c]  = busy_o;
        obs_done[c]  = done_o;
        obs_en[c]    = mem_en_o;
        obs_addr[c]  = int'(mem_addr_o);
        obs_valid[c] = out_valid_o;
        obs_sof[c]   = out_sof_o;
        obs_l0[c]    = int'(out_vec_o[0]);
        obs_l3[c]    = int'(out_vec_o[3]);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        out_ready_i = 1'b1;
        #3;
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_done", longint'(done_o), 0);
        chk("rst_mem_en", longint'(mem_en_o), 0);
        chk("rst_mem_addr", longint'(mem_addr_o), 0);
        chk("rst_valid", longint'(out_valid_o), 0);
        chk("rst_sof", longint'(out_sof_o), 0);
        chk("rst_vec", longint'(out_vec_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

`ifndef TILE_TX_GAP_EN
        //          cyc busy done en addr valid sof chkv lane0 lane3
        tbl[0]  = '{0,  0, 0, 0, 0,  0, 0, 0, 0,   0};
        tbl[1]  = '{1,  1, 0, 1, 0,  0, 0, 0, 0,   0};
        tbl[2]  = '{3,  1, 0, 1, 2,  0, 0, 0, 0,   0};
        tbl[3]  = '{4,  1, 0, 1, 3,  1, 1, 1, 0,   3};
        tbl[4]  = '{5,  1, 0, 1, 4,  1, 0, 1, 4,   7};
        tbl[5]  = '{6,  1, 0, 1, 5,  1, 0, 1, 8,   11};
        tbl[6]  = '{64, 1, 0, 1, 63, 1, 0, 1, 240, 243};
        tbl[7]  = '{65, 1, 0, 0, 63, 1, 0, 1, 244, 247};
        tbl[8]  = '{67, 1, 0, 0, 63, 1, 0, 1, 252, 255};
        tbl[9]  = '{68, 0, 1, 0, 63, 0, 0, 0, 0,   0};
        tbl[10] = '{69, 0, 0, 0, 63, 0, 0, 0, 0,   0};

        beats = 0;
        sofs  = 0;
        mon_en = 1'b1;
        start_i = 1'b1;
        rec(0);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c < 76; c++) begin
            rec(c);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tbl%0d_busy", i),  obs_busy[tbl[i].cyc],  tbl[i].busy);
            chk($sformatf("tbl%0d_done", i),  obs_done[tbl[i].cyc],  tbl[i].done);
            chk($sformatf("tbl%0d_mem_en", i), obs_en[tbl[i].cyc],   tbl[i].mem_en);
            chk($sformatf("tbl%0d_addr", i),  obs_addr[tbl[i].cyc],  tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), obs_valid[tbl[i].cyc], tbl[i].valid);
            chk($sformatf("tbl%0d_sof", i),   obs_sof[tbl[i].cyc],   tbl[i].sof);
            if (tbl[i].chk_vec) begin
                chk($sformatf("tbl%0d_lane0", i), obs_l0[tbl[i].cyc], tbl[i].lane0);
                chk($sformatf("tbl%0d_lane3", i), obs_l3[tbl[i].cyc], tbl[i].lane3);
            end
        end
        chk("f1_beats", beats, 64);
        chk("f1_sof_count", sofs, 1);
`else
        beats = 0;
        sofs  = 0;
        mon_en = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            chk($sformatf("gap_valid_c%0d", c), longint'(out_valid_o),
                (c >= 4 && c <= 193 && (c - 4) % 3 == 0) ? 1 : 0);
            chk($sformatf("gap_done_c%0d", c), longint'(done_o), (c == 194) ? 1 : 0);
            @(posedge clk); #1;
        end
        chk("gap_beats", beats, 64);
        chk("gap_sof_count", sofs, 1);
`endif

        run_frame(2, 0, 1'b0);
        run_frame(1, 20, 1'b0);
        run_frame(1, 0, 1'b1);
        run_frame(1, 0, 1'b0);

        // Mid-frame reset: abort at cycle 30, then a fresh frame from beat 0.
        beats = 0;
        mon_en = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", longint'(busy_o), 1);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", longint'(busy_o), 0);
        chk("abort_done", longint'(done_o), 0);
        chk("abort_mem_en", longint'(mem_en_o), 0);
        chk("abort_addr", longint'(mem_addr_o), 0);
        chk("abort_valid", longint'(out_valid_o), 0);
        chk("abort_sof", longint'(out_sof_o), 0);
        chk("abort_vec", longint'(out_vec_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", longint'(done_o), 0);
        end
        run_frame(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
